// File: rtl/spi_mem_arbiter_if.sv
// Shared type encoding plus the bundle of requester and controller-side signals
// seen by the two-port SPI memory arbiter.
package spi_mem_pkg;
  typedef enum logic [1:0] {
    TYPE_IDLE       = 2'd0,
    TYPE_IMEM_READ  = 2'd1,
    TYPE_DMEM_READ  = 2'd2,
    TYPE_DMEM_WRITE = 2'd3
  } mem_type_t;
endpackage

interface spi_mem_arbiter_if;
  logic [1:0]  m0_type_in;
  logic [15:0] m0_addr_in;
  logic [7:0]  m0_wdata_in;
  logic        m0_gnt_out;
  logic        m0_done_out;
  logic [15:0] m0_rdata_out;

  logic [1:0]  m1_type_in;
  logic [15:0] m1_addr_in;
  logic [7:0]  m1_wdata_in;
  logic        m1_gnt_out;
  logic        m1_done_out;
  logic [15:0] m1_rdata_out;

  logic [15:0] ctrl_addr_out;
  logic        ctrl_addr_valid_out;
  logic [1:0]  ctrl_type_out;
  logic [7:0]  ctrl_wdata_out;
  logic [15:0] ctrl_flash_data_in;
  logic        ctrl_flash_valid_in;
  logic [7:0]  ctrl_psram_data_in;
  logic        ctrl_psram_valid_in;
  logic        ctrl_busy_in;

  logic        timeout_err_out;
  logic        owner_out;

  // Environment side: requesters and the flash controller.
  modport master (
    output m0_type_in, m0_addr_in, m0_wdata_in,
    input  m0_gnt_out, m0_done_out, m0_rdata_out,
    output m1_type_in, m1_addr_in, m1_wdata_in,
    input  m1_gnt_out, m1_done_out, m1_rdata_out,
    input  ctrl_addr_out, ctrl_addr_valid_out, ctrl_type_out, ctrl_wdata_out,
    output ctrl_flash_data_in, ctrl_flash_valid_in,
    output ctrl_psram_data_in, ctrl_psram_valid_in, ctrl_busy_in,
    input  timeout_err_out, owner_out
  );

  // Arbiter side.
  modport slave (
    input  m0_type_in, m0_addr_in, m0_wdata_in,
    output m0_gnt_out, m0_done_out, m0_rdata_out,
    input  m1_type_in, m1_addr_in, m1_wdata_in,
    output m1_gnt_out, m1_done_out, m1_rdata_out,
    output ctrl_addr_out, ctrl_addr_valid_out, ctrl_type_out, ctrl_wdata_out,
    input  ctrl_flash_data_in, ctrl_flash_valid_in,
    input  ctrl_psram_data_in, ctrl_psram_valid_in, ctrl_busy_in,
    output timeout_err_out, owner_out
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Round-robin two-port arbiter that sequences one transaction at a time into the
// SPI flash/PSRAM controller, with a watchdog that aborts hung transactions.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input logic               clk_in,
  input logic               reset_in,
  spi_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_t      state;
  logic        last_owner;
  logic [CNT_W-1:0] cnt;

  logic [15:0] ctrl_addr;
  logic        ctrl_addr_valid;
  logic [1:0]  ctrl_type;
  logic [7:0]  ctrl_wdata;
  logic        gnt0, gnt1, done0, done1, timeout_err, owner;
  logic [15:0] rdata0, rdata1;

  logic        req0, req1, sel, grant;
  logic        cmp_hit, to_hit, fin, fin_err;
  logic [15:0] cmp_data, fin_data;
  logic [CNT_W:0] cnt_inc;

  always_comb begin
    req0  = bus.m0_type_in != TYPE_IDLE;
    req1  = bus.m1_type_in != TYPE_IDLE;
    // Lone requester wins outright; on a tie the port that did not go last wins.
    sel   = (req0 && req1) ? ~last_owner : req1;
    grant = (state == S_IDLE) && !bus.ctrl_busy_in && (req0 || req1);

    cmp_hit  = 1'b0;
    cmp_data = 16'h0000;
    case (ctrl_type)
      TYPE_IMEM_READ:  begin cmp_hit = bus.ctrl_flash_valid_in; cmp_data = bus.ctrl_flash_data_in; end
      TYPE_DMEM_READ:  begin cmp_hit = bus.ctrl_psram_valid_in; cmp_data = {8'h00, bus.ctrl_psram_data_in}; end
      TYPE_DMEM_WRITE: begin cmp_hit = !bus.ctrl_busy_in;       cmp_data = 16'h0000; end
      default:         begin cmp_hit = 1'b0;                    cmp_data = 16'h0000; end
    endcase
    cmp_hit = cmp_hit && (state == S_WAIT);

    // Abort on the edge that would bring the counter up to the limit.
    cnt_inc  = {1'b0, cnt} + 1'b1;
    to_hit   = (TIMEOUT_CYCLES != 0) && (state != S_IDLE) && (cnt_inc == TO_LIM);

    fin      = cmp_hit || to_hit;
    fin_err  = to_hit && !cmp_hit;
    fin_data = cmp_hit ? cmp_data : 16'hFFFF;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state           <= S_IDLE;
      last_owner      <= 1'b1;
      cnt             <= '0;
      ctrl_addr       <= 16'h0000;
      ctrl_addr_valid <= 1'b0;
      ctrl_type       <= TYPE_IDLE;
      ctrl_wdata      <= 8'h00;
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      done0           <= 1'b0;
      done1           <= 1'b0;
      rdata0          <= 16'h0000;
      rdata1          <= 16'h0000;
      timeout_err     <= 1'b0;
      owner           <= 1'b0;
    end else begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            ctrl_addr       <= sel ? bus.m1_addr_in  : bus.m0_addr_in;
            ctrl_type       <= sel ? bus.m1_type_in  : bus.m0_type_in;
            ctrl_wdata      <= sel ? bus.m1_wdata_in : bus.m0_wdata_in;
            ctrl_addr_valid <= 1'b1;
            owner           <= sel;
            last_owner      <= sel;
            gnt0            <= ~sel;
            gnt1            <= sel;
            cnt             <= '0;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (fin) begin
            if (owner) begin
              done1  <= 1'b1;
              rdata1 <= fin_data;
            end else begin
              done0  <= 1'b1;
              rdata0 <= fin_data;
            end
            timeout_err     <= fin_err;
            ctrl_addr_valid <= 1'b0;
            ctrl_type       <= TYPE_IDLE;
            state           <= S_IDLE;
          end else if (state == S_ISSUE && bus.ctrl_busy_in) begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctrl_addr_out       = ctrl_addr;
  assign bus.ctrl_addr_valid_out = ctrl_addr_valid;
  assign bus.ctrl_type_out       = ctrl_type;
  assign bus.ctrl_wdata_out      = ctrl_wdata;
  assign bus.m0_gnt_out          = gnt0;
  assign bus.m1_gnt_out          = gnt1;
  assign bus.m0_done_out         = done0;
  assign bus.m1_done_out         = done1;
  assign bus.m0_rdata_out        = rdata0;
  assign bus.m1_rdata_out        = rdata1;
  assign bus.timeout_err_out     = timeout_err;
  assign bus.owner_out           = owner;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: a transaction table plus hand-written
// sequences for arbitration, stray strobes, watchdog abort and mid-flight reset.
module tb_spi_mem_arbiter;
  import spi_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_rd [2];
  bit   lo;

  always #5 clk = ~clk;

  spi_mem_arbiter_if bus();

  spi_mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  typedef struct {
    bit          port;
    logic [1:0]  typ;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] fdata;
    logic [7:0]  pdata;
    logic [15:0] exp;
  } txn_t;

  txn_t tbl [5];

  function automatic logic gnt_of(bit p);
    return p ? bus.m1_gnt_out : bus.m0_gnt_out;
  endfunction
  function automatic logic done_of(bit p);
    return p ? bus.m1_done_out : bus.m0_done_out;
  endfunction
  function automatic logic [15:0] rdata_of(bit p);
    return p ? bus.m1_rdata_out : bus.m0_rdata_out;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(bit p, logic [1:0] t, logic [15:0] a, logic [7:0] w);
    if (p) begin
      bus.m1_type_in = t; bus.m1_addr_in = a; bus.m1_wdata_in = w;
    end else begin
      bus.m0_type_in = t; bus.m0_addr_in = a; bus.m0_wdata_in = w;
    end
  endtask

  task automatic expect_grant(bit p, logic [1:0] t, logic [15:0] a, logic [7:0] w);
    tick;
    chk("gnt",        gnt_of(p), 1);
    chk("gnt_other",  gnt_of(!p), 0);
    chk("addr_valid", bus.ctrl_addr_valid_out, 1);
    chk("ctrl_addr",  bus.ctrl_addr_out, a);
    chk("ctrl_type",  bus.ctrl_type_out, t);
    chk("ctrl_wdata", bus.ctrl_wdata_out, w);
    chk("owner",      bus.owner_out, p);
    chk("done_at_gnt", {bus.m0_done_out, bus.m1_done_out}, 0);
  endtask

  // Controller model: busy for ISSUE + two WAIT cycles, then the type's strobe.
  task automatic complete(bit p, logic [1:0] t, logic [15:0] fd, logic [7:0] pd, logic [15:0] exp);
    bus.ctrl_busy_in = 1'b1;
    tick;
    chk("gnt_clear",  {bus.m0_gnt_out, bus.m1_gnt_out}, 0);
    chk("hold_valid", bus.ctrl_addr_valid_out, 1);
    tick;
    chk("no_early_done", {bus.m0_done_out, bus.m1_done_out}, 0);
    if (t == TYPE_IMEM_READ) begin
      bus.ctrl_flash_valid_in = 1'b1; bus.ctrl_flash_data_in = fd;
    end else if (t == TYPE_DMEM_READ) begin
      bus.ctrl_psram_valid_in = 1'b1; bus.ctrl_psram_data_in = pd;
    end else begin
      bus.ctrl_busy_in = 1'b0;
    end
    tick;
    bus.ctrl_flash_valid_in = 1'b0;
    bus.ctrl_psram_valid_in = 1'b0;
    bus.ctrl_busy_in        = 1'b0;
    chk("done",        done_of(p), 1);
    chk("done_other",  done_of(!p), 0);
    chk("rdata",       rdata_of(p), exp);
    chk("rdata_other", rdata_of(!p), exp_rd[!p]);
    chk("gap_valid",   bus.ctrl_addr_valid_out, 0);
    chk("idle_type",   bus.ctrl_type_out, TYPE_IDLE);
    chk("no_timeout",  bus.timeout_err_out, 0);
    exp_rd[p] = exp;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_addr_valid"}, bus.ctrl_addr_valid_out, 0);
    chk({tag, "_type"},       bus.ctrl_type_out, TYPE_IDLE);
    chk({tag, "_addr"},       bus.ctrl_addr_out, 0);
    chk({tag, "_wdata"},      bus.ctrl_wdata_out, 0);
    chk({tag, "_gnt"},        {bus.m0_gnt_out, bus.m1_gnt_out}, 0);
    chk({tag, "_done"},       {bus.m0_done_out, bus.m1_done_out}, 0);
    chk({tag, "_rdata"},      {bus.m0_rdata_out, bus.m1_rdata_out}, 0);
    chk({tag, "_timeout"},    bus.timeout_err_out, 0);
    chk({tag, "_owner"},      bus.owner_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, TYPE_IMEM_READ,  16'h0124, 8'h00, 16'hA55A, 8'h00, 16'hA55A};
    tbl[1] = '{1, TYPE_DMEM_READ,  16'h8000, 8'h11, 16'h0000, 8'h7E, 16'h007E};
    tbl[2] = '{0, TYPE_DMEM_WRITE, 16'h0042, 8'h3C, 16'h0000, 8'h00, 16'h0000};
    tbl[3] = '{1, TYPE_IMEM_READ,  16'hFFFF, 8'h00, 16'h1234, 8'h00, 16'h1234};
    tbl[4] = '{0, TYPE_DMEM_READ,  16'h0000, 8'h00, 16'h0000, 8'hFF, 16'h00FF};
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;

    set_req(0, TYPE_IDLE, 0, 0);
    set_req(1, TYPE_IDLE, 0, 0);
    bus.ctrl_flash_data_in = 0; bus.ctrl_flash_valid_in = 0;
    bus.ctrl_psram_data_in = 0; bus.ctrl_psram_valid_in = 0;
    bus.ctrl_busy_in = 0;
    tick; tick;
    chk_all_zero("reset");
    rst = 1'b0;
    tick;
    chk("idle_no_gnt", {bus.m0_gnt_out, bus.m1_gnt_out}, 0);

    foreach (tbl[i]) begin
      set_req(tbl[i].port, tbl[i].typ, tbl[i].addr, tbl[i].wdata);
      expect_grant(tbl[i].port, tbl[i].typ, tbl[i].addr, tbl[i].wdata);
      set_req(tbl[i].port, TYPE_IDLE, 0, 0);
      complete(tbl[i].port, tbl[i].typ, tbl[i].fdata, tbl[i].pdata, tbl[i].exp);
    end

    // Flash strobe during a DMEM read must be ignored.
    set_req(0, TYPE_DMEM_READ, 16'h0055, 8'h00);
    expect_grant(0, TYPE_DMEM_READ, 16'h0055, 8'h00);
    set_req(0, TYPE_IDLE, 0, 0);
    bus.ctrl_busy_in = 1'b1;
    tick;
    bus.ctrl_flash_valid_in = 1'b1; bus.ctrl_flash_data_in = 16'hDEAD;
    tick;
    bus.ctrl_flash_valid_in = 1'b0;
    chk("stray_no_done", bus.m0_done_out, 0);
    chk("stray_hold_valid", bus.ctrl_addr_valid_out, 1);
    bus.ctrl_psram_valid_in = 1'b1; bus.ctrl_psram_data_in = 8'h99;
    tick;
    bus.ctrl_psram_valid_in = 1'b0; bus.ctrl_busy_in = 1'b0;
    chk("stray_done", bus.m0_done_out, 1);
    chk("stray_rdata", bus.m0_rdata_out, 16'h0099);
    exp_rd[0] = 16'h0099;
    lo = 1'b0;

    // Both ports request continuously: grants must alternate.
    for (int i = 0; i < 6; i++) begin
      bit p;
      logic [15:0] a;
      set_req(0, TYPE_IMEM_READ, 16'h0100 + 16'(i), 8'h00);
      set_req(1, TYPE_IMEM_READ, 16'h0200 + 16'(i), 8'h00);
      p = !lo;
      a = p ? 16'h0200 + 16'(i) : 16'h0100 + 16'(i);
      expect_grant(p, TYPE_IMEM_READ, a, 8'h00);
      lo = p;
      complete(p, TYPE_IMEM_READ, 16'hC000 + 16'(i), 8'h00, 16'hC000 + 16'(i));
    end
    set_req(0, TYPE_IDLE, 0, 0);
    set_req(1, TYPE_IDLE, 0, 0);

    // Watchdog: controller stays busy and never strobes.
    set_req(0, TYPE_DMEM_READ, 16'h0777, 8'h00);
    expect_grant(0, TYPE_DMEM_READ, 16'h0777, 8'h00);
    set_req(0, TYPE_IDLE, 0, 0);
    bus.ctrl_busy_in = 1'b1;
    set_req(1, TYPE_IMEM_READ, 16'h0300, 8'h00);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("wd_no_err", bus.timeout_err_out, 0);
      chk("wd_no_done", {bus.m0_done_out, bus.m1_done_out}, 0);
    end
    tick;
    chk("wd_err", bus.timeout_err_out, 1);
    chk("wd_done", bus.m0_done_out, 1);
    chk("wd_done_other", bus.m1_done_out, 0);
    chk("wd_rdata", bus.m0_rdata_out, 16'hFFFF);
    chk("wd_drop_valid", bus.ctrl_addr_valid_out, 0);
    exp_rd[0] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wd_busy_no_gnt", {bus.m0_gnt_out, bus.m1_gnt_out}, 0);
      chk("wd_err_pulse", bus.timeout_err_out, 0);
    end
    bus.ctrl_busy_in = 1'b0;
    expect_grant(1, TYPE_IMEM_READ, 16'h0300, 8'h00);
    set_req(1, TYPE_IDLE, 0, 0);
    complete(1, TYPE_IMEM_READ, 16'hBEEF, 8'h00, 16'hBEEF);

    // Reset while waiting on the controller.
    set_req(1, TYPE_IMEM_READ, 16'h0400, 8'h00);
    expect_grant(1, TYPE_IMEM_READ, 16'h0400, 8'h00);
    set_req(1, TYPE_IDLE, 0, 0);
    bus.ctrl_busy_in = 1'b1;
    tick; tick;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    tick; tick;
    bus.ctrl_busy_in = 1'b0;
    rst = 1'b0;
    tick;
    chk("rst_no_done", {bus.m0_done_out, bus.m1_done_out}, 0);

    // Simultaneous requests after reset: port 0 first, then port 1 after a gap.
    set_req(0, TYPE_DMEM_WRITE, 16'h0010, 8'h3C);
    set_req(1, TYPE_DMEM_READ,  16'h0020, 8'h00);
    expect_grant(0, TYPE_DMEM_WRITE, 16'h0010, 8'h3C);
    set_req(0, TYPE_IDLE, 0, 0);
    complete(0, TYPE_DMEM_WRITE, 16'h0, 8'h0, 16'h0000);
    expect_grant(1, TYPE_DMEM_READ, 16'h0020, 8'h00);
    set_req(1, TYPE_IDLE, 0, 0);
    complete(1, TYPE_DMEM_READ, 16'h0, 8'hA7, 16'h00A7);
    tick;
    chk("final_done_drop", {bus.m0_done_out, bus.m1_done_out}, 0);
    chk("final_owner", bus.owner_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Two-requester arbiter and transaction sequencer in front of spi_flash_controller.
- Port 0 is the CPU fetch/load/store path; port 1 is a second master, such as a debug loader or DMA engine.
- Captures one request, drives the controller's addr/addr_valid/mem_type/data interface until completion, then returns read data and a done pulse to the owner.
- Round-robin fairness and a watchdog timeout ensure a hung SPI transaction cannot deadlock the system.

Parameters:
- TIMEOUT_CYCLES, 1023, max cycles from ISSUE entry to completion before abort; 0 disables the watchdog.
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  asynchronous, active-high reset
- m0_type_in  input  2  mem_type_t request; TYPE_IDLE means no request
- m0_addr_in  input  16  request address
- m0_wdata_in  input  8  write data for TYPE_DMEM_WRITE
- m0_gnt_out  output  1  1-cycle pulse: request captured
- m0_done_out  output  1  1-cycle pulse: transaction finished
- m0_rdata_out  output  16  read data, valid with m0_done_out
- m1_type_in, m1_addr_in, m1_wdata_in, m1_gnt_out, m1_done_out, m1_rdata_out: same as port 0
- ctrl_addr_out  output  16  to controller addr_in
- ctrl_addr_valid_out  output  1  to controller addr_valid_in
- ctrl_type_out  output  2  to controller mem_type_in
- ctrl_wdata_out  output  8  to controller psram_data_in
- ctrl_flash_data_in  input  16  controller flash_data_out
- ctrl_flash_valid_in  input  1  controller flash_data_valid_out
- ctrl_psram_data_in  input  8  controller psram_data_out
- ctrl_psram_valid_in  input  1  controller psram_data_valid_out
- ctrl_busy_in  input  1  controller busy_out
- timeout_err_out  output  1  1-cycle pulse on watchdog abort
- owner_out  output  1  owner of current or last transaction

Behaviour:

Reset (asynchronous, active-high):
- State IDLE.
- All outputs 0; ctrl_type_out = TYPE_IDLE.
- last_owner = 1, so port 0 wins the first tie.
- Counter 0.
- Reset mid-transaction abandons it silently; no done pulse.

State IDLE:
- ctrl_addr_valid_out = 0 and ctrl_type_out = TYPE_IDLE.
- Grant only if ctrl_busy_in = 0 and at least one mX_type_in != TYPE_IDLE.
- One requester: grant it.
- Both requesting: grant the port != last_owner.
- On grant, in the same edge:
  - latch type, addr and wdata into holding registers;
  - set owner_out and last_owner;
  - pulse mX_gnt_out;
  - clear counter;
  - go to ISSUE.
- The requester may change its inputs from the cycle after gnt.

State ISSUE:
- ctrl_addr_valid_out = 1; ctrl_addr_out, ctrl_type_out and ctrl_wdata_out come from the holding registers.
- Go to WAIT_DONE on ctrl_busy_in = 1.

State WAIT_DONE:
- ctrl_* outputs held as in ISSUE.
- Completion condition by latched type:
  - TYPE_IMEM_READ: ctrl_flash_valid_in = 1; rdata = ctrl_flash_data_in.
  - TYPE_DMEM_READ: ctrl_psram_valid_in = 1; rdata = {8'h00, ctrl_psram_data_in}.
  - TYPE_DMEM_WRITE: ctrl_busy_in = 0; rdata = 16'h0000.
- On completion:
  - register rdata into mX_rdata_out of the owner (the other port's rdata is unchanged);
  - pulse mX_done_out in the next cycle;
  - go to IDLE.
- Valid strobes that do not match the latched type are ignored.

Inter-transaction gap:
- The IDLE cycle after completion guarantees at least 1 cycle of ctrl_addr_valid_out = 0 between transactions.
- A new grant takes at least 1 cycle in IDLE, so there is no back-to-back addr_valid.

Watchdog:
- Counter increments every cycle in ISSUE or WAIT_DONE and saturates.
- If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES:
  - pulse timeout_err_out;
  - pulse owner done with rdata = 16'hFFFF;
  - drop ctrl_addr_valid_out;
  - go to IDLE.
- IDLE then waits for ctrl_busy_in = 0 before the next grant.
- Completion and timeout in the same cycle: completion wins, with no err pulse.

Other rules:
- gnt and done never pulse on both ports in the same cycle.
- At most one transaction is outstanding.
- Latency for an idle bus, with the request seen at cycle 0:
  - gnt at edge 1;
  - ctrl_addr_valid_out high from cycle 1;
  - done one cycle after the controller's completion strobe.

Test Plan:
1. m0 IMEM read, addr 16'h0124, model returns 16'hA55A after busy: m0_gnt_out pulses once, ctrl_addr_out = 16'h0124, ctrl_type_out = TYPE_IMEM_READ, then m0_done_out with m0_rdata_out = 16'hA55A, m1 outputs stay 0.
2. m0 DMEM write and m1 DMEM read requested in the same cycle after reset: m0 granted first, wdata 8'h3C on ctrl_wdata_out, done when busy falls; then m1 granted, rdata = 16'h00xx; ctrl_addr_valid_out low for at least 1 cycle between the two.
3. Both ports request continuously for 6 transactions: grants alternate 0,1,0,1,0,1; owner_out tracks each grant.
4. TIMEOUT_CYCLES = 8, model never asserts a valid strobe and holds busy: timeout_err_out pulses after 8 cycles in ISSUE/WAIT_DONE, owner done with rdata 16'hFFFF, no new grant while busy = 1.
5. DMEM read active and stray ctrl_flash_valid_in pulse: ignored; completion only on ctrl_psram_valid_in.
6. reset_in asserted in WAIT_DONE: all outputs 0 asynchronously with no done pulse; after release, first tie goes to m0.
